// File: rtl/mem_io_responder_if.sv
// Signal bundle between the CPU byte bus / UART and mem_io_responder.
// The responder uses the slave modport; the CPU+UART side (or a bench) uses master.
interface mem_io_responder_if;
  logic        bus_en;
  logic [31:0] bus_a;
  logic [7:0]  bus_wdata;
  logic        bus_wr;
  logic [7:0]  bus_rdata;
  logic        io_buffer_full;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        halt_out;

  modport slave (
    input  bus_en, bus_a, bus_wdata, bus_wr, tx_ready, rx_valid, rx_data,
    output bus_rdata, io_buffer_full, tx_valid, tx_data, rx_ready, halt_out
  );

  modport master (
    output bus_en, bus_a, bus_wdata, bus_wr, tx_ready, rx_valid, rx_data,
    input  bus_rdata, io_buffer_full, tx_valid, tx_data, rx_ready, halt_out
  );
endinterface

// File: rtl/mem_io_responder.sv
// Target side of the CPU byte bus: program/data RAM, I/O window at a[17:16]==2'b11, UART TX/RX FIFOs.
// Optional: define MEMIO_TX_OVF_CNT_EN for a saturating dropped-TX-push counter at 0x30008/0x30009.
module mem_io_responder #(
  parameter int MEM_BITS     = 17,
  parameter int TX_DEPTH_BIT = 3,
  parameter int RX_DEPTH_BIT = 3,
  parameter int FULL_MARGIN  = 2
) (
  input  logic               clk_in,
  input  logic               rst_n_in,
  mem_io_responder_if.slave  bus
);

  localparam int TX_DEPTH = 1 << TX_DEPTH_BIT;
  localparam int RX_DEPTH = 1 << RX_DEPTH_BIT;
  localparam logic [TX_DEPTH_BIT:0] TX_FULL_CNT  = (TX_DEPTH_BIT+1)'(TX_DEPTH);
  localparam logic [TX_DEPTH_BIT:0] TX_NEAR_FULL = (TX_DEPTH_BIT+1)'(TX_DEPTH - FULL_MARGIN);
  localparam logic [RX_DEPTH_BIT:0] RX_FULL_CNT  = (RX_DEPTH_BIT+1)'(RX_DEPTH);

  localparam logic [15:0] OFF_DATA   = 16'h0000;
  localparam logic [15:0] OFF_CNT0   = 16'h0004;
  localparam logic [15:0] OFF_CNT1   = 16'h0005;
  localparam logic [15:0] OFF_CNT2   = 16'h0006;
  localparam logic [15:0] OFF_CNT3   = 16'h0007;
  localparam logic [15:0] OFF_OVF_LO = 16'h0008;
  localparam logic [15:0] OFF_OVF_HI = 16'h0009;

  // Access decode
  logic                rd_req, wr_req, is_io;
  logic [15:0]         io_off;
  logic [MEM_BITS-1:0] ram_addr;
  logic                unused_addr;

  assign rd_req      = bus.bus_en && !bus.bus_wr;
  assign wr_req      = bus.bus_en && bus.bus_wr;
  assign is_io       = (bus.bus_a[17:16] == 2'b11);
  assign io_off      = bus.bus_a[15:0];
  assign ram_addr    = bus.bus_a[MEM_BITS-1:0];
  assign unused_addr = ^bus.bus_a;

  // NOTE: storage arrays carry no reset; only their pointers and counts are reset.
  logic [7:0] ram [2**MEM_BITS];
  always_ff @(posedge clk_in) begin
    if (wr_req && !is_io) ram[ram_addr] <= bus.bus_wdata;
  end

  // TX FIFO: CPU pushes, UART pops
  logic [7:0]              tx_mem [TX_DEPTH];
  logic [TX_DEPTH_BIT-1:0] tx_wr_ptr_q, tx_wr_ptr_d, tx_rd_ptr_q, tx_rd_ptr_d;
  logic [TX_DEPTH_BIT:0]   tx_count_q, tx_count_d;
  logic                    tx_full, tx_nonempty, tx_push_req, tx_push, tx_pop;
  logic [7:0]              tx_push_data;

  assign tx_full      = (tx_count_q == TX_FULL_CNT);
  assign tx_nonempty  = (tx_count_q != '0);
  assign tx_push_req  = wr_req && is_io &&
                        ((io_off == OFF_DATA && bus.bus_wdata != 8'h00) || io_off == OFF_CNT0);
  assign tx_push      = tx_push_req && !tx_full;
  assign tx_pop       = tx_nonempty && bus.tx_ready;
  assign tx_push_data = (io_off == OFF_CNT0) ? 8'h00 : bus.bus_wdata;

  always_ff @(posedge clk_in) begin
    if (tx_push) tx_mem[tx_wr_ptr_q] <= tx_push_data;
  end

  // RX FIFO: UART pushes, CPU pops via reads of 0x30000
  logic [7:0]              rx_mem [RX_DEPTH];
  logic [RX_DEPTH_BIT-1:0] rx_wr_ptr_q, rx_wr_ptr_d, rx_rd_ptr_q, rx_rd_ptr_d;
  logic [RX_DEPTH_BIT:0]   rx_count_q, rx_count_d;
  logic                    rx_full, rx_nonempty, rx_push, rx_pop;

  assign rx_full     = (rx_count_q == RX_FULL_CNT);
  assign rx_nonempty = (rx_count_q != '0);
  assign rx_push     = bus.rx_valid && !rx_full;
  assign rx_pop      = rd_req && is_io && io_off == OFF_DATA && rx_nonempty;

  always_ff @(posedge clk_in) begin
    if (rx_push) rx_mem[rx_wr_ptr_q] <= bus.rx_data;
  end

  logic [7:0] ovf_lo, ovf_hi;
`ifdef MEMIO_TX_OVF_CNT_EN
  logic [15:0] ovf_cnt_q, ovf_cnt_d;

  always_comb begin
    ovf_cnt_d = ovf_cnt_q;
    if (wr_req && is_io && io_off == OFF_OVF_LO) ovf_cnt_d = 16'h0000;
    else if (tx_push_req && tx_full && ovf_cnt_q != 16'hFFFF) ovf_cnt_d = ovf_cnt_q + 16'd1;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) ovf_cnt_q <= 16'h0000;
    else           ovf_cnt_q <= ovf_cnt_d;
  end

  assign ovf_lo = ovf_cnt_q[7:0];
  assign ovf_hi = ovf_cnt_q[15:8];
`else
  assign ovf_lo = 8'h00;
  assign ovf_hi = 8'h00;
`endif

  logic [31:0] cycle_cnt_q, cycle_cnt_d, snap_q, snap_d;
  logic        halt_q, halt_d, io_full_q, io_full_d;
  logic [7:0]  rdata_q, rdata_d;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    tx_wr_ptr_d = tx_push ? tx_wr_ptr_q + TX_DEPTH_BIT'(1) : tx_wr_ptr_q;
    tx_rd_ptr_d = tx_pop  ? tx_rd_ptr_q + TX_DEPTH_BIT'(1) : tx_rd_ptr_q;
    tx_count_d  = tx_count_q;
    case ({tx_push, tx_pop})
      2'b10:   tx_count_d = tx_count_q + (TX_DEPTH_BIT+1)'(1);
      2'b01:   tx_count_d = tx_count_q - (TX_DEPTH_BIT+1)'(1);
      default: tx_count_d = tx_count_q;
    endcase

    rx_wr_ptr_d = rx_push ? rx_wr_ptr_q + RX_DEPTH_BIT'(1) : rx_wr_ptr_q;
    rx_rd_ptr_d = rx_pop  ? rx_rd_ptr_q + RX_DEPTH_BIT'(1) : rx_rd_ptr_q;
    rx_count_d  = rx_count_q;
    case ({rx_push, rx_pop})
      2'b10:   rx_count_d = rx_count_q + (RX_DEPTH_BIT+1)'(1);
      2'b01:   rx_count_d = rx_count_q - (RX_DEPTH_BIT+1)'(1);
      default: rx_count_d = rx_count_q;
    endcase

    cycle_cnt_d = cycle_cnt_q + 32'd1;
    snap_d      = snap_q;
    halt_d      = halt_q || (wr_req && is_io && io_off == OFF_CNT0);
    io_full_d   = (tx_count_q >= TX_NEAR_FULL);
    rdata_d     = rdata_q;

    if (rd_req) begin
      if (!is_io) begin
        rdata_d = ram[ram_addr];
      end else begin
        case (io_off)
          OFF_DATA:   rdata_d = rx_nonempty ? rx_mem[rx_rd_ptr_q] : 8'h00;
          OFF_CNT0: begin
            rdata_d = cycle_cnt_q[7:0];
            snap_d  = cycle_cnt_q;
          end
          OFF_CNT1:   rdata_d = snap_q[15:8];
          OFF_CNT2:   rdata_d = snap_q[23:16];
          OFF_CNT3:   rdata_d = snap_q[31:24];
          OFF_OVF_LO: rdata_d = ovf_lo;
          OFF_OVF_HI: rdata_d = ovf_hi;
          default:    rdata_d = 8'h00;
        endcase
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      tx_wr_ptr_q <= '0;
      tx_rd_ptr_q <= '0;
      tx_count_q  <= '0;
      rx_wr_ptr_q <= '0;
      rx_rd_ptr_q <= '0;
      rx_count_q  <= '0;
      cycle_cnt_q <= 32'h0;
      snap_q      <= 32'h0;
      halt_q      <= 1'b0;
      io_full_q   <= 1'b0;
      rdata_q     <= 8'h00;
    end else begin
      tx_wr_ptr_q <= tx_wr_ptr_d;
      tx_rd_ptr_q <= tx_rd_ptr_d;
      tx_count_q  <= tx_count_d;
      rx_wr_ptr_q <= rx_wr_ptr_d;
      rx_rd_ptr_q <= rx_rd_ptr_d;
      rx_count_q  <= rx_count_d;
      cycle_cnt_q <= cycle_cnt_d;
      snap_q      <= snap_d;
      halt_q      <= halt_d;
      io_full_q   <= io_full_d;
      rdata_q     <= rdata_d;
    end
  end

  // tx_data is forced to zero when empty so the unreset FIFO array never leaks out after reset
  assign bus.bus_rdata      = rdata_q;
  assign bus.io_buffer_full = io_full_q;
  assign bus.tx_valid       = tx_nonempty;
  assign bus.tx_data        = tx_nonempty ? tx_mem[tx_rd_ptr_q] : 8'h00;
  assign bus.rx_ready       = !rx_full;
  assign bus.halt_out       = halt_q;

endmodule

// File: tb/tb_mem_io_responder.sv
// Randomized scoreboard bench for mem_io_responder: a queue-based reference model predicts
// read data, TX bytes and status flags; a negedge monitor compares them against the DUT.
module tb_mem_io_responder;
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   n_checks = 0;
  int   n_pass   = 0;

  mem_io_responder_if bus_if ();

  mem_io_responder dut (
    .clk_in   (clk),
    .rst_n_in (rst_n),
    .bus      (bus_if)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [7:0]  mem_m [logic [16:0]];
  logic [7:0]  tx_q[$];
  logic [7:0]  rx_q[$];
  logic [7:0]  rd_q[$];
  logic [16:0] written[$];
  logic [31:0] cnt_m  = 32'h0;
  logic [31:0] snap_m = 32'h0;
  logic        halt_m = 1'b0;
  logic        full_m = 1'b0;
  logic [15:0] ovf_m  = 16'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // One clock edge of the bus/UART behaviour, seen at the level of queues and byte values
  task automatic model_step();
    int          tx_n, rx_n;
    logic        io;
    logic [15:0] off;
    logic [16:0] key;
    logic [7:0]  exp_rd;
    if (!rst_n) begin
      tx_q.delete(); rx_q.delete(); rd_q.delete();
      cnt_m = 0; snap_m = 0; halt_m = 0; full_m = 0; ovf_m = 0;
      return;
    end
    tx_n = tx_q.size();
    rx_n = rx_q.size();
    io   = (bus_if.bus_a[17:16] == 2'b11);
    off  = bus_if.bus_a[15:0];
    key  = bus_if.bus_a[16:0];
    full_m = (tx_n >= 6);
    if (bus_if.tx_ready && tx_n != 0) void'(tx_q.pop_front());
    if (bus_if.bus_en && bus_if.bus_wr) begin
      if (!io) mem_m[key] = bus_if.bus_wdata;
      else if ((off == 16'h0 && bus_if.bus_wdata != 8'h00) || off == 16'h4) begin
        if (off == 16'h4) halt_m = 1'b1;
        if (tx_n < 8) tx_q.push_back(off == 16'h4 ? 8'h00 : bus_if.bus_wdata);
        else if (ovf_m != 16'hFFFF) ovf_m++;
      end else if (off == 16'h8) ovf_m = 16'h0;
    end
    if (bus_if.bus_en && !bus_if.bus_wr) begin
      exp_rd = 8'h00;
      if (!io) exp_rd = mem_m.exists(key) ? mem_m[key] : 8'h00;
      else begin
        case (off)
          16'h0: if (rx_n != 0) exp_rd = rx_q.pop_front();
          16'h4: begin exp_rd = cnt_m[7:0]; snap_m = cnt_m; end
          16'h5: exp_rd = snap_m[15:8];
          16'h6: exp_rd = snap_m[23:16];
          16'h7: exp_rd = snap_m[31:24];
`ifdef MEMIO_TX_OVF_CNT_EN
          16'h8: exp_rd = ovf_m[7:0];
          16'h9: exp_rd = ovf_m[15:8];
`endif
          default: exp_rd = 8'h00;
        endcase
      end
      rd_q.push_back(exp_rd);
    end
    if (bus_if.rx_valid && rx_n < 8) rx_q.push_back(bus_if.rx_data);
    cnt_m++;
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    model_step();
  end

  // Monitor: compares whatever the DUT presents against the model
  initial forever begin
    @(negedge clk);
    #1;
    check("tx_valid", bus_if.tx_valid, tx_q.size() != 0);
    if (tx_q.size() != 0) check("tx_data", bus_if.tx_data, tx_q[0]);
    check("rx_ready", bus_if.rx_ready, rx_q.size() < 8);
    check("io_buffer_full", bus_if.io_buffer_full, full_m);
    check("halt_out", bus_if.halt_out, halt_m);
    if (rd_q.size() != 0) check("bus_rdata", bus_if.bus_rdata, rd_q.pop_front());
  end

  task automatic drive(input logic en, input logic wr, input logic [31:0] a, input logic [7:0] d);
    @(negedge clk);
    bus_if.bus_en    = en;
    bus_if.bus_wr    = wr;
    bus_if.bus_a     = a;
    bus_if.bus_wdata = d;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 32'h0, 8'h00);
  endtask

  function automatic logic [31:0] io_addr(input logic [15:0] off);
    logic [31:0] a;
    a = $urandom();
    a[17:16] = 2'b11;
    a[15:0]  = off;
    return a;
  endfunction

  function automatic logic [31:0] ram_addr(input logic [16:0] key);
    logic [31:0] a;
    a = $urandom();
    a[16:0] = key;
    if (key[16]) a[17] = 1'b0;
    return a;
  endfunction

  task automatic check_reset_outputs();
    check("rst bus_rdata", bus_if.bus_rdata, 8'h00);
    check("rst io_buffer_full", bus_if.io_buffer_full, 1'b0);
    check("rst tx_valid", bus_if.tx_valid, 1'b0);
    check("rst tx_data", bus_if.tx_data, 8'h00);
    check("rst rx_ready", bus_if.rx_ready, 1'b1);
    check("rst halt_out", bus_if.halt_out, 1'b0);
  endtask

  initial begin
    int unsigned sel;
    logic [16:0] k;
    bus_if.bus_en = 1'b0; bus_if.bus_wr = 1'b0; bus_if.bus_a = 32'h0; bus_if.bus_wdata = 8'h00;
    bus_if.tx_ready = 1'b0; bus_if.rx_valid = 1'b0; bus_if.rx_data = 8'h00;
    #2 rst_n = 1'b0;
    #1 check_reset_outputs();
    @(negedge clk);
    rst_n = 1'b1;

    // RAM write then read back
    drive(1'b1, 1'b1, 32'h0001_0010 & 32'h0000_FFFF, 8'hA5);
    drive(1'b0, 1'b0, 32'h0000_0010, 8'h00);
    written.push_back(17'h00010);
    idle(2);

    // TX: 'H','i',0x00 with the UART stalled, then drain
    drive(1'b1, 1'b1, io_addr(16'h0), 8'h48);
    drive(1'b1, 1'b1, io_addr(16'h0), 8'h69);
    drive(1'b1, 1'b1, io_addr(16'h0), 8'h00);
    idle(2);
    check("tx two queued head", bus_if.tx_data, 8'h48);
    bus_if.tx_ready = 1'b1;
    idle(4);
    bus_if.tx_ready = 1'b0;

    // Fill TX to overflow: 8 accepted, 9th dropped
    for (int i = 0; i < 9; i++) drive(1'b1, 1'b1, io_addr(16'h0), 8'(i + 1));
    idle(2);
    check("io_buffer_full after fill", bus_if.io_buffer_full, 1'b1);
    drive(1'b0, 1'b0, io_addr(16'h8), 8'h00);
    drive(1'b0, 1'b0, io_addr(16'h9), 8'h00);
    bus_if.tx_ready = 1'b1;
    idle(10);
    check("io_buffer_full after drain", bus_if.io_buffer_full, 1'b0);
    bus_if.tx_ready = 1'b0;

    // RX: one byte in, two reads
    @(negedge clk);
    bus_if.rx_valid = 1'b1; bus_if.rx_data = 8'h31;
    @(negedge clk);
    bus_if.rx_valid = 1'b0;
    drive(1'b0, 1'b0, io_addr(16'h0), 8'h00);
    drive(1'b0, 1'b0, io_addr(16'h0), 8'h00);
    idle(1);

    // Cycle counter snapshot ~100 cycles after reset
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    idle(100);
    for (int i = 4; i < 8; i++) drive(1'b0, 1'b0, io_addr(16'(i)), 8'h00);
    idle(1);

    // Halt write pushes a 0x00 to TX
    drive(1'b1, 1'b1, io_addr(16'h4), 8'h77);
    idle(2);
    check("halt_out set", bus_if.halt_out, 1'b1);
    bus_if.tx_ready = 1'b1;
    idle(2);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      sel = $urandom_range(0, 15);
      case (sel)
        0, 1: drive(1'b0, 1'b0, $urandom(), $urandom());
        2, 3: begin
          k = 17'($urandom_range(0, 511));
          k[16] = 1'($urandom_range(0, 1));
          written.push_back(k);
          drive(1'b1, 1'b1, ram_addr(k), $urandom());
        end
        4, 5: begin
          k = written[$urandom_range(0, written.size() - 1)];
          drive(1'b0, 1'b0, ram_addr(k), $urandom());
        end
        6, 7, 8: drive(1'b1, 1'b1, io_addr(16'h0),
                       ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(1, 255)));
        9, 14: drive(1'b0, 1'b0, io_addr(16'h0), 8'h00);
        10, 15: drive(1'b0, 1'b0, io_addr(16'($urandom_range(4, 9))), 8'h00);
        11: drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  io_addr(16'($urandom_range(10, 300))), $urandom());
        12: drive(1'b1, 1'b1, io_addr(16'h8), $urandom());
        default: drive(1'b1, 1'b1, io_addr(16'h4), $urandom());
      endcase
      bus_if.tx_ready = (i < 700) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      bus_if.rx_valid = ($urandom_range(0, 2) == 0);
      bus_if.rx_data  = 8'($urandom());
    end

    // Reset in the middle of an I/O write
    bus_if.tx_ready = 1'b0;
    drive(1'b1, 1'b1, io_addr(16'h0), 8'h55);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs();
    drive(1'b0, 1'b0, 32'h0, 8'h00);
    bus_if.rx_valid = 1'b0;
    rst_n = 1'b1;
    drive(1'b0, 1'b0, ram_addr(written[0]), 8'h00);
    idle(3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
